// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, with start/done handshake.
// Optional macro SERSUB_ADD_EN adds an `op` input selecting add (1) or subtract (0).
module serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERSUB_ADD_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             neg,
    output logic             ovfl
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic             add_q, add_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovfl_q, ovfl_d;

    logic             a0, b0, bit_c, bor_next_c, ovfl_c;
    logic [WIDTH-1:0] res_full_c;
    logic             op_in;

`ifdef SERSUB_ADD_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    // Shared full add/subtract cell; add_q selects carry vs borrow propagation
    always_comb begin
        a0         = a_sh_q[0];
        b0         = b_sh_q[0];
        bit_c      = a0 ^ b0 ^ bor_q;
        bor_next_c = add_q ? ((a0 & b0) | ((a0 ^ b0) & bor_q))
                           : ((~a0 & b0) | (~(a0 ^ b0) & bor_q));
        res_full_c = {bit_c, res_q};
        ovfl_c     = add_q ? ((amsb_q == bmsb_q) && (res_full_c[WIDTH-1] != amsb_q))
                           : ((amsb_q != bmsb_q) && (res_full_c[WIDTH-1] != amsb_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            add_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            add_q   <= add_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovfl_q  <= ovfl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        add_d   = add_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovfl_d  = ovfl_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    add_d   = op_in;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_full_c[WIDTH-1:1];
                bor_d  = bor_next_c;
                // Final bit: publish results straight from the cell output
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_full_c;
                    bout_d  = bor_next_c;
                    zero_d  = (res_full_c == '0);
                    neg_d   = res_full_c[WIDTH-1];
                    ovfl_d  = ovfl_c;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign zero       = zero_q;
    assign neg        = neg_q;
    assign ovfl       = ovfl_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a monitor pops and checks on every done pulse. Define SERSUB_ADD_EN for add-mode vectors.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, borrow_out, zero, neg, ovfl;
    logic [WIDTH-1:0] diff;
`ifdef SERSUB_ADD_EN
    logic             op;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
`ifdef SERSUB_ADD_EN
        .op         (op),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .neg        (neg),
        .ovfl       (ovfl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo, z, n, v;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts busy cycles and checks every done pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with empty scoreboard (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("diff",       32'(diff),       32'(e.d));
                    chk("borrow_out", 32'(borrow_out), 32'(e.bo));
                    chk("zero",       32'(zero),       32'(e.z));
                    chk("neg",        32'(neg),        32'(e.n));
                    chk("ovfl",       32'(ovfl),       32'(e.v));
                    chk("latency",    32'(cyc - e.acc), 32'(WIDTH));
                    chk("busy_cycles", 32'(busy_cnt),  32'(WIDTH));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 32'(k < 40), 32'd1);
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic bo, input logic z,
                        input logic n, input logic v, input int acc);
        exp_t e;
        e.d = d; e.bo = bo; e.z = z; e.n = n; e.v = v; e.acc = acc;
        sb.push_back(e);
    endtask

    // One operation: start for one cycle, scramble inputs afterwards, optionally poke start while busy
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic o,
                         input logic [WIDTH-1:0] d, input logic bo, input logic z,
                         input logic n, input logic v, input bit poke);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
`ifdef SERSUB_ADD_EN
        op = o;
`else
        if (o) $display("note: op ignored without add mode");
`endif
        @(posedge clk);
        #1;
        push(d, bo, z, n, v, cyc);
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = 16'h5A5A;
        if (poke) begin
            repeat (3) begin
                @(negedge clk); start = 1'b1; a = 16'hAAAA; b = 16'h5555;
                @(negedge clk); start = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERSUB_ADD_EN
        op = 1'b0;
`endif
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({borrow_out, zero, neg, ovfl}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1..3: basic, negative result, signed overflow both ways
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("held_diff", 32'(diff), 32'h0002);
        chk("held_done", 32'(done), 32'd0);
        do_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // 4: equal operands, then start held high through DONE -> back-to-back 0 - 1
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1;
        push(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
        push(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, cyc + WIDTH + 1);
        a = 16'h0000; b = 16'h0001;
        repeat (WIDTH + 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        wait_done();

        // 5: reset mid-operation aborts it
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_flags", 32'({borrow_out, zero, neg, ovfl}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done_diff", 32'(diff), 32'd0);
        do_op(16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SERSUB_ADD_EN
        // 6: add mode
        do_op(16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
